// File: rtl/benes_pkg.sv
// Shared sizing and types for the 8x8 Benes route controller.
package benes_pkg;
  localparam int N_PORTS      = 8;
  localparam int STAGES       = 5;
  localparam int SW_PER_STAGE = N_PORTS / 2;
  localparam int STG_IDX_W    = $clog2(STAGES);

  typedef logic [SW_PER_STAGE-1:0] stage_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    APPLY
  } route_state_t;
endpackage

// File: rtl/benes_route_ctrl_if.sv
// Config, commit and beat-tag signals between the SW host/network and the route controller.
interface benes_route_ctrl_if;
  import benes_pkg::*;

  logic                             cfg_valid;
  logic                             cfg_ready;
  logic [STG_IDX_W-1:0]             cfg_stage;
  stage_cfg_t                       cfg_bits;
  logic                             cfg_err;
  logic                             cmt_req;
  logic                             cmt_ack;
  logic                             busy;
  logic                             in_valid;
  logic [STAGES*SW_PER_STAGE-1:0]   switch_set;
  logic                             out_valid;
  logic                             out_epoch;

  modport master (
    output cfg_valid, cfg_stage, cfg_bits, cmt_req, in_valid,
    input  cfg_ready, cfg_err, cmt_ack, busy, switch_set, out_valid, out_epoch
  );

  modport slave (
    input  cfg_valid, cfg_stage, cfg_bits, cmt_req, in_valid,
    output cfg_ready, cfg_err, cmt_ack, busy, switch_set, out_valid, out_epoch
  );
endinterface

// File: rtl/benes_tag_pipe.sv
// Resettable {valid,epoch} shift register matching the network's register depth.
module benes_tag_pipe #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_epoch,
  output logic out_valid,
  output logic out_epoch
);
  logic [DEPTH:1] vld_pipe;
  logic [DEPTH:1] ep_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ep_pipe  <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      // Epoch is gated so idle slots carry a clean 0 tag.
      ep_pipe[1]  <= in_epoch & in_valid;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        ep_pipe[i]  <= ep_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[DEPTH];
  assign out_epoch = ep_pipe[DEPTH];
endmodule

// File: rtl/benes_route_ctrl.sv
// Shadow/active config banks for a 5-stage Benes network; commits roll out one stage per cycle.
module benes_route_ctrl
  import benes_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  benes_route_ctrl_if.slave bus
);
  route_state_t         state, state_nxt;
  stage_cfg_t           shadow [STAGES];
  stage_cfg_t           active [STAGES];
  logic [STAGES-1:0]    mask;
  logic [STAGES-1:0]    wr_hit;
  logic [STG_IDX_W-1:0] cnt;
  logic                 epoch;
  logic                 wr_acc, wr_ok, commit, last;

  assign commit        = (state == READY) && bus.cmt_req;
  assign bus.cfg_ready = (state != APPLY) && !commit;
  assign wr_acc        = bus.cfg_valid && bus.cfg_ready;
  assign wr_ok         = wr_acc && (|wr_hit);
  assign last          = (cnt == STG_IDX_W'(STAGES-1));
  assign bus.busy      = (state == APPLY);

  // One-hot decode of the target stage; all-zero flags an out-of-range index.
  always_comb begin
    wr_hit = '0;
    for (int s = 0; s < STAGES; s++)
      if (bus.cfg_stage == STG_IDX_W'(s)) wr_hit[s] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (wr_ok && (&(mask | wr_hit))) state_nxt = READY;
      READY:   if (commit) state_nxt = APPLY;
      APPLY:   if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask        <= '0;
      cnt         <= '0;
      epoch       <= 1'b0;
      bus.cmt_ack <= 1'b0;
      bus.cfg_err <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        shadow[s] <= '0;
        active[s] <= '0;
      end
    end else begin
      bus.cmt_ack <= commit;
      bus.cfg_err <= wr_acc && !(|wr_hit);
      if (commit) begin
        active[0] <= shadow[0];
        epoch     <= ~epoch;
        mask      <= '0;
        cnt       <= STG_IDX_W'(1);
      end else begin
        if (wr_ok) mask <= mask | wr_hit;
        if (state == APPLY) begin
          cnt <= last ? '0 : cnt + 1'b1;
          for (int s = 1; s < STAGES; s++)
            if (cnt == STG_IDX_W'(s)) active[s] <= shadow[s];
        end
      end
      for (int s = 0; s < STAGES; s++)
        if (wr_ok && wr_hit[s]) shadow[s] <= bus.cfg_bits;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_sw
    assign bus.switch_set[s*SW_PER_STAGE +: SW_PER_STAGE] = active[s];
  end

  benes_tag_pipe #(.DEPTH(STAGES)) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_epoch  (epoch),
    .out_valid (bus.out_valid),
    .out_epoch (bus.out_epoch)
  );
endmodule

// File: tb/tb_benes_route_ctrl.sv
// Vector table, directed corner sequences and random traffic against a cycle-level behavioural model.
module tb_benes_route_ctrl;
  import benes_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  benes_route_ctrl_if bus();

  benes_route_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [2:0]  st;
    logic [3:0]  b;
    logic        cr;
    logic        iv;
    logic        chk;
    logic        rdy;
    logic        ack;
    logic        err;
    logic        bsy;
    logic [19:0] sw;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [3:0]  m_sh [5];
  logic [3:0]  bank [2][5];
  logic [4:0]  m_mask;
  logic        m_epoch, have_c, e_ack, e_err;
  int          c_cyc, cyc;
  logic        ov [8];
  logic        tg [8];
  int          ent [8];
  logic [19:0] hist [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Routes port indices through the network: switch cross swaps a pair,
  // stages are joined by unshuffle on the way in and shuffle on the way out.
  function automatic logic [23:0] route(input logic [19:0] cfg);
    logic [2:0] p [8];
    logic [2:0] q [8];
    logic [2:0] t, ii;
    logic [23:0] r;
    for (int i = 0; i < 8; i++) p[i] = 3'(i);
    for (int s = 0; s < 5; s++) begin
      for (int j = 0; j < 4; j++)
        if (cfg[s*4+j]) begin t = p[2*j]; p[2*j] = p[2*j+1]; p[2*j+1] = t; end
      if (s < 4) begin
        for (int i = 0; i < 8; i++) begin
          ii = 3'(i);
          if (s < 2) q[{ii[0], ii[2:1]}] = p[i];
          else       q[{ii[1:0], ii[2]}] = p[i];
        end
        for (int i = 0; i < 8; i++) p[i] = q[i];
      end
    end
    for (int i = 0; i < 8; i++) r[i*3 +: 3] = p[i];
    return r;
  endfunction

  function automatic vec_t mk(input logic v, input logic [2:0] st, input logic [3:0] b,
                              input logic cr, input logic iv, input logic c, input logic rdy,
                              input logic ack, input logic err, input logic bsy, input logic [19:0] sw);
    vec_t t;
    t.v = v; t.st = st; t.b = b; t.cr = cr; t.iv = iv; t.chk = c;
    t.rdy = rdy; t.ack = ack; t.err = err; t.bsy = bsy; t.sw = sw;
    return t;
  endfunction

  function automatic vec_t rnd(input logic v, input logic [2:0] st, input logic [3:0] b, input logic cr);
    return mk(v, st, b, cr, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0);
  endfunction

  task automatic model_reset();
    m_mask = '0; m_epoch = 1'b0; have_c = 1'b0; e_ack = 1'b0; e_err = 1'b0; c_cyc = 0;
    for (int s = 0; s < 5; s++) begin m_sh[s] = '0; bank[0][s] = '0; bank[1][s] = '0; end
    for (int i = 0; i < 8; i++) begin ov[i] = 1'b0; tg[i] = 1'b0; ent[i] = 0; hist[i] = '0; end
  endtask

  // Caller is #1 past a rising edge; outputs are sampled on the falling edge.
  task automatic step(input vec_t t);
    logic [19:0] e_sw, act, ref_cfg;
    logic applying, full, e_rdy, commit, acc;
    int sl, ns;
    bus.cfg_valid = t.v; bus.cfg_stage = t.st; bus.cfg_bits = t.b;
    bus.cmt_req = t.cr; bus.in_valid = t.iv;
    @(negedge clk);
    applying = have_c && (cyc > c_cyc) && (cyc < c_cyc + STAGES);
    full     = (m_mask == 5'h1F);
    e_rdy    = !applying && !(full && t.cr);
    for (int s = 0; s < 5; s++)
      e_sw[s*4 +: 4] = (!have_c || cyc >= c_cyc + 1 + s) ? bank[m_epoch][s] : bank[!m_epoch][s];
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(e_rdy));
    chk("cmt_ack", 32'(bus.cmt_ack), 32'(e_ack));
    chk("cfg_err", 32'(bus.cfg_err), 32'(e_err));
    chk("busy", 32'(bus.busy), 32'(applying));
    chk("switch_set", 32'(bus.switch_set), 32'(e_sw));
    if (t.chk) begin
      chk("tv_ready", 32'(bus.cfg_ready), 32'(t.rdy));
      chk("tv_ack", 32'(bus.cmt_ack), 32'(t.ack));
      chk("tv_err", 32'(bus.cfg_err), 32'(t.err));
      chk("tv_busy", 32'(bus.busy), 32'(t.bsy));
      chk("tv_switch_set", 32'(bus.switch_set), 32'(t.sw));
    end
    hist[cyc % 8] = bus.switch_set;
    sl = cyc % 8;
    chk("out_valid", 32'(bus.out_valid), 32'(ov[sl]));
    if (ov[sl] && bus.out_valid) begin
      chk("out_epoch", 32'(bus.out_epoch), 32'(tg[sl]));
      for (int s = 0; s < 5; s++) begin
        act[s*4 +: 4]     = hist[(ent[sl] + s) % 8][s*4 +: 4];
        ref_cfg[s*4 +: 4] = bank[tg[sl]][s];
      end
      chk("beat_route", 32'(route(act)), 32'(route(ref_cfg)));
    end
    ov[sl] = 1'b0;
    ns = (cyc + STAGES) % 8;
    ov[ns] = t.iv; tg[ns] = m_epoch; ent[ns] = cyc;
    commit = full && !applying && t.cr;
    acc    = t.v && e_rdy;
    e_ack  = commit;
    e_err  = acc && (t.st >= 3'd5);
    if (acc && t.st < 3'd5) begin m_sh[t.st] = t.b; m_mask[t.st] = 1'b1; end
    if (commit) begin
      for (int s = 0; s < 5; s++) bank[!m_epoch][s] = m_sh[s];
      m_epoch = !m_epoch; m_mask = '0; have_c = 1'b1; c_cyc = cyc;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.cfg_valid = 1'b0; bus.cfg_stage = '0; bus.cfg_bits = '0;
    bus.cmt_req = 1'b0; bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_switch_set", 32'(bus.switch_set), 32'h0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t tv [14];
  int   nack;

  initial begin
    cyc = 0;
    //            v    st    b     cr   iv  chk  rdy  ack  err  bsy  sw
    tv[0]  = mk(1'b1, 3'd0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
    tv[1]  = mk(1'b1, 3'd1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
    tv[2]  = mk(1'b1, 3'd2, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
    tv[3]  = mk(1'b1, 3'd3, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
    tv[4]  = mk(1'b1, 3'd5, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
    tv[5]  = mk(1'b0, 3'd0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00000);
    tv[6]  = mk(1'b1, 3'd4, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
    tv[7]  = mk(1'b1, 3'd0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000);
    tv[8]  = mk(1'b1, 3'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 20'h0000F);
    tv[9]  = mk(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h000FF);
    tv[10] = mk(1'b0, 3'd0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00FFF);
    tv[11] = mk(1'b0, 3'd0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20'h0FFFF);
    tv[12] = mk(1'b0, 3'd0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'hFFFFF);
    tv[13] = mk(1'b0, 3'd0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20'hFFFFF);

    #2;
    do_reset();
    for (int i = 0; i < 14; i++) step(tv[i]);
    for (int i = 0; i < 8; i++) step(mk(1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0));

    // Partial load with commit held: no ack until the last stage lands.
    step(rnd(1'b1, 3'd0, 4'hA, 1'b0));
    step(rnd(1'b1, 3'd1, 4'h5, 1'b0));
    step(rnd(1'b1, 3'd2, 4'h3, 1'b0));
    step(rnd(1'b1, 3'd3, 4'hC, 1'b0));
    nack = 0;
    for (int i = 0; i < 10; i++) begin
      step(rnd(1'b0, 3'd0, 4'h0, 1'b1));
      nack += int'(bus.cmt_ack);
    end
    chk("partial_no_ack", 32'(nack), 32'h0);
    step(rnd(1'b1, 3'd4, 4'h6, 1'b1));
    chk("partial_ready_state_ack", 32'(bus.cmt_ack), 32'h0);
    step(rnd(1'b1, 3'd1, 4'h0, 1'b1));
    chk("late_commit_ack", 32'(bus.cmt_ack), 32'h1);
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      step(rnd(1'b1, 3'd2, 4'h1, 1'b1));
      nack += int'(bus.cmt_ack);
    end
    chk("apply_no_second_ack", 32'(nack), 32'h0);

    // Out-of-range stage: single error pulse, mask untouched.
    step(rnd(1'b1, 3'd7, 4'hF, 1'b0));
    chk("err_pulse", 32'(bus.cfg_err), 32'h1);
    step(rnd(1'b0, 3'd0, 4'h0, 1'b1));
    chk("err_clear", 32'(bus.cfg_err), 32'h0);
    step(rnd(1'b0, 3'd0, 4'h0, 1'b1));
    chk("err_no_ack", 32'(bus.cmt_ack), 32'h0);

    // Reset in the middle of a wavefront.
    for (int s = 0; s < 5; s++) step(rnd(1'b1, 3'(s), 4'h9, 1'b0));
    step(rnd(1'b0, 3'd0, 4'h0, 1'b1));
    step(rnd(1'b0, 3'd0, 4'h0, 1'b0));
    step(rnd(1'b0, 3'd0, 4'h0, 1'b0));
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      logic [2:0] st;
      st = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      step(rnd(1'($urandom_range(0, 1)), st, 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 2) == 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
